// File: rtl/des_round_sequencer.sv
// -----------------------------------------------------------------------------
// des_round_sequencer
//
// Control FSM for an iterative DES core. It accepts one block per start
// handshake and steps the shared round datapath through LOAD (IP / PC-1),
// ROUNDS round iterations and FINAL (FP of the swapped halves). It then holds
// the result-valid flag until the consumer takes it. No data passes through
// this block; it only produces strobes, the round index and the key-schedule
// rotation control.
//
// Ports:
//   clk, rst_n      system clock (rising edge), asynchronous active-low reset
//   start_valid     requester presents block + key on the datapath inputs
//   start_ready     high only in IDLE
//   mode_decrypt    0 = encrypt, 1 = decrypt; sampled at the start handshake
//   dp_load         datapath loads IP(block) -> L/R and PC-1(key) -> C/D
//   dp_round_en     datapath performs one round this cycle
//   round_idx       current round index (0-based); 0 outside ROUND
//   key_shift_amt   C/D rotation amount for this round (0..2); 0 outside ROUND
//   key_shift_dir   0 = rotate left, 1 = rotate right; latched mode LOAD..OUT
//   dp_final        datapath captures FP({R,L}) into its output register
//   out_valid       result register valid; held until out_ready
//   out_ready       consumer accepts the result
//   busy            high in every state except IDLE
//   blocks_done     count of completed output handshakes (wraps)
// -----------------------------------------------------------------------------
module des_round_sequencer #(
  parameter int ROUNDS = 16,  // legal 1..16; only 16 is DES-compliant
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             mode_decrypt,
  output logic             dp_load,
  output logic             dp_round_en,
  output logic [3:0]       round_idx,
  output logic [1:0]       key_shift_amt,
  output logic             key_shift_dir,
  output logic             dp_final,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] blocks_done
);

  localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_FINAL,
    S_OUT
  } state_t;

  state_t           state_reg;
  logic             start_ready_reg;
  logic             dp_load_reg;
  logic             dp_round_en_reg;
  logic [3:0]       round_idx_reg;
  logic [1:0]       key_shift_amt_reg;
  logic             key_shift_dir_reg;  // doubles as the latched mode register
  logic             dp_final_reg;
  logic             out_valid_reg;
  logic             busy_reg;
  logic [CNT_W-1:0] blocks_done_reg;

  // Per-round C/D rotation. Encryption rotates left before every round.
  // Decryption rotates right after the first round: round 0 works on the
  // unrotated PC-1 output, which equals the round-16 encrypt key because the
  // full schedule rotates by 28 positions in total.
  function automatic logic [1:0] shift_amt(input logic [3:0] idx, input logic dec);
    logic [1:0] amt;
    case (idx)
      4'd0:              amt = dec ? 2'd0 : 2'd1;
      4'd1, 4'd8, 4'd15: amt = 2'd1;
      default:           amt = 2'd2;
    endcase
    return amt;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= S_IDLE;
      start_ready_reg   <= 1'b1;
      dp_load_reg       <= 1'b0;
      dp_round_en_reg   <= 1'b0;
      round_idx_reg     <= 4'd0;
      key_shift_amt_reg <= 2'd0;
      key_shift_dir_reg <= 1'b0;
      dp_final_reg      <= 1'b0;
      out_valid_reg     <= 1'b0;
      busy_reg          <= 1'b0;
      blocks_done_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start_valid) begin
            state_reg         <= S_LOAD;
            start_ready_reg   <= 1'b0;
            busy_reg          <= 1'b1;
            dp_load_reg       <= 1'b1;
            key_shift_dir_reg <= mode_decrypt;
          end
        end

        S_LOAD: begin
          state_reg         <= S_ROUND;
          dp_load_reg       <= 1'b0;
          dp_round_en_reg   <= 1'b1;
          round_idx_reg     <= 4'd0;
          key_shift_amt_reg <= shift_amt(4'd0, key_shift_dir_reg);
        end

        S_ROUND: begin
          if (round_idx_reg == LAST_IDX) begin
            state_reg         <= S_FINAL;
            dp_round_en_reg   <= 1'b0;
            round_idx_reg     <= 4'd0;
            key_shift_amt_reg <= 2'd0;
            dp_final_reg      <= 1'b1;
          end else begin
            round_idx_reg     <= round_idx_reg + 4'd1;
            key_shift_amt_reg <= shift_amt(round_idx_reg + 4'd1, key_shift_dir_reg);
          end
        end

        S_FINAL: begin
          state_reg     <= S_OUT;
          dp_final_reg  <= 1'b0;
          out_valid_reg <= 1'b1;
        end

        S_OUT: begin
          if (out_ready) begin
            state_reg         <= S_IDLE;
            out_valid_reg     <= 1'b0;
            start_ready_reg   <= 1'b1;
            busy_reg          <= 1'b0;
            key_shift_dir_reg <= 1'b0;
            blocks_done_reg   <= blocks_done_reg + CNT_W'(1);
          end
        end

        default: begin
          // Unreachable encodings recover to a clean IDLE.
          state_reg         <= S_IDLE;
          start_ready_reg   <= 1'b1;
          dp_load_reg       <= 1'b0;
          dp_round_en_reg   <= 1'b0;
          round_idx_reg     <= 4'd0;
          key_shift_amt_reg <= 2'd0;
          key_shift_dir_reg <= 1'b0;
          dp_final_reg      <= 1'b0;
          out_valid_reg     <= 1'b0;
          busy_reg          <= 1'b0;
        end
      endcase
    end
  end

  assign start_ready   = start_ready_reg;
  assign dp_load       = dp_load_reg;
  assign dp_round_en   = dp_round_en_reg;
  assign round_idx     = round_idx_reg;
  assign key_shift_amt = key_shift_amt_reg;
  assign key_shift_dir = key_shift_dir_reg;
  assign dp_final      = dp_final_reg;
  assign out_valid     = out_valid_reg;
  assign busy          = busy_reg;
  assign blocks_done   = blocks_done_reg;

endmodule

// File: tb/tb_des_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_des_round_sequencer
//
// Directed bench for des_round_sequencer (ROUNDS=16). A table of block
// records (mode, output stall, mid-block mode toggle, expected shift sum) is
// run through a per-cycle expected-output timeline. Hand-written sequences
// cover reset mid-round and back-to-back throughput.
// -----------------------------------------------------------------------------
module tb_des_round_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic        mode_decrypt;
  logic        dp_load;
  logic        dp_round_en;
  logic [3:0]  round_idx;
  logic [1:0]  key_shift_amt;
  logic        key_shift_dir;
  logic        dp_final;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [15:0] blocks_done;

  des_round_sequencer #(.ROUNDS(16), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .mode_decrypt (mode_decrypt),
    .dp_load      (dp_load),
    .dp_round_en  (dp_round_en),
    .round_idx    (round_idx),
    .key_shift_amt(key_shift_amt),
    .key_shift_dir(key_shift_dir),
    .dp_final     (dp_final),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .blocks_done  (blocks_done)
  );

  always #5 clk = ~clk;

  // {start_ready, busy, dp_load, dp_round_en, dp_final, out_valid, dir, amt, idx}
  logic [12:0] act_v;
  assign act_v = {start_ready, busy, dp_load, dp_round_en, dp_final, out_valid,
                  key_shift_dir, key_shift_amt, round_idx};

  int n_checks = 0;
  int n_pass   = 0;
  int bd_exp   = 0;

  logic [1:0] enc_sched [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  logic [1:0] dec_sched [16] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  typedef struct {
    logic dec;
    int   stall;
    logic toggle;
    int   exp_sum;
  } blk_t;

  blk_t blks [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [12:0] pack(input logic sr, input logic bz, input logic ld,
                                       input logic rn, input logic fn, input logic ov,
                                       input logic dir, input logic [1:0] amt,
                                       input logic [3:0] idx);
    return {sr, bz, ld, rn, fn, ov, dir, amt, idx};
  endfunction

  // Called at a negedge. Runs one block and checks every cycle of it.
  task automatic run_block(input int id, input logic dec, input int stall,
                           input logic toggle, input int exp_sum);
    int          n;
    int          sum;
    logic [12:0] e;
    logic [1:0]  s;
    n   = 0;
    sum = 0;
    while (!start_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("blk%0d ready_wait", id), 32'(start_ready), 32'd1);
    mode_decrypt = dec;
    start_valid  = 1'b1;
    @(negedge clk);
    start_valid  = 1'b0;
    for (int k = 1; k <= 20 + stall; k++) begin
      if (k == 1)
        e = pack(0, 1, 1, 0, 0, 0, dec, 2'd0, 4'd0);
      else if (k <= 17) begin
        s = dec ? dec_sched[k-2] : enc_sched[k-2];
        e = pack(0, 1, 0, 1, 0, 0, dec, s, 4'(k - 2));
      end else if (k == 18)
        e = pack(0, 1, 0, 0, 1, 0, dec, 2'd0, 4'd0);
      else if (k <= 19 + stall)
        e = pack(0, 1, 0, 0, 0, 1, dec, 2'd0, 4'd0);
      else
        e = pack(1, 0, 0, 0, 0, 0, 1'b0, 2'd0, 4'd0);
      check($sformatf("blk%0d cyc%0d outputs", id, k), 32'(act_v), 32'(e));
      if (dp_round_en) sum += int'(key_shift_amt);
      if (toggle && k == 5) mode_decrypt = ~dec;
      if (k == 19 || k == 19 + stall)
        check($sformatf("blk%0d cyc%0d blocks_done held", id, k),
              32'(blocks_done), 32'(bd_exp));
      if (k == 19 + stall) out_ready = 1'b1;
      if (k == 20 + stall) begin
        bd_exp++;
        check($sformatf("blk%0d blocks_done", id), 32'(blocks_done), 32'(bd_exp));
        out_ready = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    check($sformatf("blk%0d shift_sum", id), 32'(sum), 32'(exp_sum));
  endtask

  initial begin
    int   acc_t [3];
    int   na;
    int   cyc;
    logic latched;

    blks[0] = '{dec: 1'b0, stall: 0, toggle: 1'b0, exp_sum: 28};
    blks[1] = '{dec: 1'b1, stall: 0, toggle: 1'b0, exp_sum: 27};
    blks[2] = '{dec: 1'b0, stall: 5, toggle: 1'b0, exp_sum: 28};
    blks[3] = '{dec: 1'b1, stall: 2, toggle: 1'b1, exp_sum: 27};
    blks[4] = '{dec: 1'b0, stall: 1, toggle: 1'b1, exp_sum: 28};

    rst_n        = 1'b0;
    start_valid  = 1'b0;
    mode_decrypt = 1'b0;
    out_ready    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", 32'(act_v), 32'(pack(1, 0, 0, 0, 0, 0, 0, 2'd0, 4'd0)));
    check("reset blocks_done", 32'(blocks_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_block(i, blks[i].dec, blks[i].stall, blks[i].toggle, blks[i].exp_sum);

    // Reset during round 7 of a decrypt block.
    mode_decrypt = 1'b1;
    start_valid  = 1'b1;
    @(negedge clk);
    start_valid  = 1'b0;
    repeat (8) @(negedge clk);
    check("pre-reset round_idx", 32'(round_idx), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("async reset outputs", 32'(act_v), 32'(pack(1, 0, 0, 0, 0, 0, 0, 2'd0, 4'd0)));
    check("async reset blocks_done", 32'(blocks_done), 32'd0);
    bd_exp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_block(5, 1'b0, 0, 1'b0, 28);

    // Back-to-back: start_valid and out_ready held high, mode toggling every cycle.
    na        = 0;
    cyc       = 0;
    latched   = 1'b0;
    out_ready = 1'b1;
    start_valid = 1'b1;
    while (!(na == 3 && int'(blocks_done) == bd_exp + 3) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (na == 3) start_valid = 1'b0;
      if (busy)
        check($sformatf("b2b cyc%0d key_shift_dir", cyc), 32'(key_shift_dir), 32'(latched));
      mode_decrypt = ~mode_decrypt;
      if (start_valid && start_ready) begin
        latched   = mode_decrypt;
        acc_t[na] = cyc;
        na++;
      end
    end
    check("b2b accepts", 32'(na), 32'd3);
    check("b2b gap0", 32'(acc_t[1] - acc_t[0]), 32'd20);
    check("b2b gap1", 32'(acc_t[2] - acc_t[1]), 32'd20);
    check("b2b blocks_done", 32'(blocks_done), 32'(bd_exp + 3));
    out_ready   = 1'b0;
    start_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/des_round_sequencer.md
Name: des_round_sequencer

Overview:
- Control FSM for the iterative DES core: one start handshake in, one result handshake out.
- Sequences Initial Permutation / key PC-1 load, the round iterations and the Final Permutation capture (L/R swap) in the shared round datapath.
- Generates round index, key-rotation amount and direction per round for encrypt and decrypt.
- Sits between the block-level request interface and the round/key-schedule datapath; holds no data itself.

Parameters:
- ROUNDS, 16, number of round iterations; legal 1..16. Only 16 is DES-compliant; lower values are for reduced-round bring-up.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_valid  input  1  requester has a block+key on the datapath inputs.
- start_ready  output  1  sequencer can accept a block.
- mode_decrypt  input  1  0=encrypt, 1=decrypt; sampled at start handshake.
- dp_load  output  1  datapath captures IP(block) into L/R and PC-1(key) into C/D.
- dp_round_en  output  1  datapath performs one round this cycle.
- round_idx  output  4  current round, 0-based.
- key_shift_amt  output  2  C/D rotation amount applied this round (0, 1 or 2).
- key_shift_dir  output  1  0=rotate left (encrypt), 1=rotate right (decrypt).
- dp_final  output  1  datapath captures FP({R,L}) into output register.
- out_valid  output  1  result register valid.
- out_ready  input  1  consumer accepts result.
- busy  output  1  high in every state except IDLE.
- blocks_done  output  CNT_W  count of completed output handshakes.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; start_ready=1; all other outputs 0, including round_idx, key_shift_amt, key_shift_dir, blocks_done. Reset mid-operation aborts the block immediately; no partial out_valid.
- States: IDLE -> LOAD -> ROUND -> FINAL -> OUT -> IDLE.
- IDLE: start_ready=1. If start_valid=1, latch mode_decrypt into the mode register and move to LOAD. start_ready=0 in all other states.
- LOAD, 1 cycle: dp_load=1. Move to ROUND with round_idx=0.
- ROUND, ROUNDS cycles: dp_round_en=1; round_idx increments each cycle. After round_idx=ROUNDS-1, move to FINAL.
- FINAL, 1 cycle: dp_final=1; dp_round_en=0. Move to OUT.
- OUT: out_valid=1, held stable until out_ready=1. On handshake: blocks_done+1 (wraps at 2^CNT_W to 0), return to IDLE.
- Latency: handshake at edge T gives dp_load in cycle T+1, rounds in T+2..T+ROUNDS+1, dp_final in T+ROUNDS+2, out_valid from T+ROUNDS+3 (T+19 for 16 rounds).
- Throughput: next start accepted one cycle after the output handshake, giving 20 cycles per block minimum.
- Round outputs: key_shift_dir = latched mode for the whole block. round_idx, key_shift_amt and key_shift_dir are 0 outside ROUND, except key_shift_dir, which holds the latched mode from LOAD through OUT.
- Encrypt shift schedule (rounds 0..15): 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Decrypt shift schedule: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (right rotate, first round unrotated).
- mode_decrypt and start_valid changes after acceptance are ignored.
- out_ready asserted outside OUT is ignored.
- dp_load, dp_round_en and dp_final are mutually exclusive, and each fires only in its own state.

Test Plan:
1. Reset then pulse start_valid with mode_decrypt=0 at edge T -> start_ready drops at T+1; dp_load=1 only in T+1; dp_round_en=1 for exactly 16 cycles with round_idx 0..15; key_shift_amt sequence 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; dp_final at T+18; out_valid at T+19. Key-shift sum = 28.
2. Decrypt (mode_decrypt=1) -> key_shift_dir=1 from LOAD through OUT; amt sequence 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; sum = 27.
3. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid held, start_ready=0, blocks_done unchanged. Then out_ready=1 -> blocks_done=1 and start_ready=1 next cycle.
4. Back-to-back: start_valid and out_ready held high for 3 blocks -> accepts exactly 20 cycles apart; blocks_done=3. Toggling mode_decrypt mid-block has no effect on key_shift_dir.
5. Assert rst_n=0 during round 7 -> all outputs 0 and start_ready=1 asynchronously; after release a new block completes normally with out_valid 19 cycles after acceptance.
6. With an attached DES datapath, key 133457799BBCDFF1 and plaintext 0123456789ABCDEF -> encrypt output 85E813540F0AB405. Feeding 85E813540F0AB405 back in decrypt mode -> 0123456789ABCDEF.
